// File: rtl/data_mem_if.sv
// Request/response bus between the MEM stage and data_mem_ctrl.
// The pipeline side uses the master modport; the memory controller uses slave.
interface data_mem_if #(
  parameter int WORD_LEN = 32
);
  logic                req;
  logic                writeEn;
  logic [1:0]          size;
  logic [WORD_LEN-1:0] address;
  logic [WORD_LEN-1:0] dataIn;
  logic                ready;
  logic                done;
  logic                err;
  logic [WORD_LEN-1:0] dataOut;

  modport master (
    output req, writeEn, size, address, dataIn,
    input  ready, done, err, dataOut
  );

  modport slave (
    input  req, writeEn, size, address, dataIn,
    output ready, done, err, dataOut
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle big-endian data memory with byte/half/word access, wait states and error reporting.
// Optional macro DATA_MEM_CLEAR_ON_RESET_EN: zero the whole array one word per cycle after reset.
module data_mem_ctrl #(
  parameter int WORD_LEN    = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);
  localparam int BYTES = WORD_LEN / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH_WORDS);
  localparam logic [WORD_LEN-1:0] BASE     = WORD_LEN'(BASE_ADDR);
  localparam logic [WORD_LEN-1:0] SPAN     = WORD_LEN'(DEPTH_WORDS * BYTES);
  localparam logic [3:0]          LAST_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    ST_CLEAR,
`endif
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic [WORD_LEN-1:0] addr_q;
  logic [WORD_LEN-1:0] data_q;
  logic                ready_q;
  logic                done_q;
  logic                err_q;
  logic [WORD_LEN-1:0] dout_q;
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
  logic [IDXW-1:0]     clr_q;
`endif

  logic [WORD_LEN-1:0] offset;
  logic [LB-1:0]       boff;
  logic                in_hole;
  logic                bad;
  logic [WORD_LEN-1:0] rd_word;
  logic [WORD_LEN-1:0] rd_val;
  logic [WORD_LEN-1:0] wr_word;
  logic [BYTES-1:0]    wr_be;

  // Lane gi holds bits [gi*8 +: 8]; the lowest byte address maps to the top lane.
  always_comb begin
    offset  = addr_q - BASE;
    boff    = offset[LB-1:0];
    in_hole = (addr_q < BASE);
    bad     = 1'b0;
    if (!in_hole) begin
      if (offset >= SPAN) begin
        bad = 1'b1;
      end else begin
        case (size_q)
          2'b00:   bad = 1'b0;
          2'b01:   bad = boff[0];
          2'b10:   bad = (boff != '0);
          default: bad = 1'b1;
        endcase
      end
    end
    rd_val  = rd_word;
    wr_word = data_q;
    wr_be   = '1;
    case (size_q)
      2'b00: begin
        rd_val  = (rd_word >> (8 * (BYTES - 1 - int'(boff)))) & WORD_LEN'(8'hFF);
        wr_word = {BYTES{data_q[7:0]}};
        wr_be   = BYTES'(1) << (BYTES - 1 - int'(boff));
      end
      2'b01: begin
        rd_val  = (rd_word >> (8 * (BYTES - 2 - int'({boff[LB-1:1], 1'b0})))) & WORD_LEN'(16'hFFFF);
        wr_word = {(BYTES / 2){data_q[15:0]}};
        wr_be   = BYTES'(3) << (BYTES - 2 - int'({boff[LB-1:1], 1'b0}));
      end
      default: ;
    endcase
  end

  logic                mem_we;
  logic [IDXW-1:0]     mem_widx;
  logic [WORD_LEN-1:0] mem_wdata;
  logic [BYTES-1:0]    mem_be;
  logic                rd_en;
  logic [IDXW-1:0]     rd_idx;

  // The read is launched at acceptance so the data is waiting by the final ACCESS edge.
  always_comb begin
    mem_we    = (state_q == ST_ACCESS) && (cnt_q == LAST_CNT) && we_q && !in_hole && !bad && !rst;
    mem_widx  = IDXW'(offset >> LB);
    mem_wdata = wr_word;
    mem_be    = wr_be;
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
    if ((state_q == ST_CLEAR) && !rst) begin
      mem_we    = 1'b1;
      mem_widx  = clr_q;
      mem_wdata = '0;
      mem_be    = '1;
    end
`endif
    rd_en  = (state_q == ST_IDLE) && ready_q && bus.req && !rst;
    rd_idx = IDXW'((bus.address - BASE) >> LB);
  end

  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];
      logic [7:0] lane_rd_q;
      always_ff @(posedge clk) begin
        if (mem_we && mem_be[gi]) lane_mem[mem_widx] <= mem_wdata[gi*8 +: 8];
        if (rd_en) lane_rd_q <= lane_mem[rd_idx];
      end
      assign rd_word[gi*8 +: 8] = lane_rd_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
      state_q <= ST_CLEAR;
      clr_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
`ifdef DATA_MEM_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          clr_q <= clr_q + IDXW'(1);
          if (clr_q == IDXW'(DEPTH_WORDS - 1)) state_q <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (ready_q && bus.req) begin
            we_q    <= bus.writeEn;
            size_q  <= bus.size;
            addr_q  <= bus.address;
            data_q  <= bus.dataIn;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_ACCESS;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == LAST_CNT) begin
            done_q  <= 1'b1;
            err_q   <= bad;
            dout_q  <= (we_q || in_hole || bad) ? '0 : rd_val;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_RESP: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.dataOut = dout_q;
endmodule
